// File: rtl/pio_spi_tx_bridge.sv
// PIO-to-SPI transmit bridge: buffers bytes written by the output PIO in a small
// FIFO and sends each one as its own SPI mode-0 frame, capturing the MISO byte.
module pio_spi_tx_bridge #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH),
  localparam int unsigned LW        = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    tx_data,
  input  logic          tx_load,
  input  logic          ovf_clr,
  input  logic          miso,
  output logic          sclk,
  output logic          mosi,
  output logic          ss_n,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic          busy,
  output logic [LW-1:0] fifo_level,
  output logic          overflow
);

  localparam logic [7:0]    HalfMax = 8'(CLK_DIV - 1);
  localparam logic [LW-1:0] Full    = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e        state_q, state_d;
  logic [7:0]    hcnt_q, hcnt_d;
  logic [3:0]    ecnt_q, ecnt_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          sclk_d, mosi_d, ss_n_d, rx_valid_d, overflow_d;
  logic [7:0]    rx_data_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic          full, empty, push, drop, pop, try_pop, half_done;

  assign full       = (level_q == Full);
  assign empty      = (level_q == '0);
  // A full FIFO drops the byte even if a pop happens on the same edge.
  assign push       = tx_load & ~full;
  assign drop       = tx_load & full;
  assign overflow_d = drop | (overflow & ~ovf_clr);
  assign half_done  = (hcnt_q == HalfMax);
  assign busy       = (state_q != StIdle) | ~empty;
  assign fifo_level = level_q;

  // FIFO data array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= tx_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q  <= level_q + LW'(push) - LW'(pop);
      overflow <= overflow_d;
    end
  end

  // FSM state, counters, shifters and registered SPI outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      hcnt_q   <= '0;
      ecnt_q   <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      ecnt_q   <= ecnt_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      sclk     <= sclk_d;
      mosi     <= mosi_d;
      ss_n     <= ss_n_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
    end
  end

  // Next-state logic, SPI edge generation and the pop decision.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    ecnt_d     = ecnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    sclk_d     = sclk;
    mosi_d     = mosi;
    ss_n_d     = ss_n;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    try_pop    = 1'b0;
    pop        = 1'b0;
    case (state_q)
      StIdle: try_pop = 1'b1;
      StSetup: begin
        if (half_done) begin
          hcnt_d  = '0;
          ecnt_d  = '0;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso};
          state_d = StShift;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      StShift: begin
        if (half_done) begin
          hcnt_d = '0;
          ecnt_d = ecnt_q + 4'd1;
          if (sclk) begin
            sclk_d = 1'b0;
            // Edge 14 of this state is the 8th falling edge: keep bit0 on mosi.
            if (ecnt_q == 4'd14) begin
              state_d = StHold;
            end else begin
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
              mosi_d  = tx_sh_q[6];
            end
          end else begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], miso};
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      StHold: begin
        if (half_done) begin
          hcnt_d     = '0;
          ss_n_d     = 1'b1;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          mosi_d     = 1'b0;
          state_d    = StGap;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      StGap: begin
        if (half_done) begin
          hcnt_d  = '0;
          state_d = StIdle;
          // Pop on the same edge so back-to-back bytes need no idle cycle.
          try_pop = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (try_pop && !empty) begin
      pop     = 1'b1;
      tx_sh_d = mem_q[rptr_q];
      mosi_d  = mem_q[rptr_q][7];
      ss_n_d  = 1'b0;
      hcnt_d  = '0;
      state_d = StSetup;
    end
  end

endmodule

// File: tb/tb_pio_spi_tx_bridge.sv
// Bench for pio_spi_tx_bridge: a CLK_DIV=4 instance driven against a timing/FIFO
// model of the byte stream, plus a CLK_DIV=1 instance in MISO-MOSI loopback.
module tb_pio_spi_tx_bridge;
  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int PER   = 18 * D;

  logic       clk, reset_n;
  logic [7:0] tx_data, rx_data;
  logic       tx_load, ovf_clr, miso, sclk, mosi, ss_n, rx_valid, busy, overflow;
  logic [2:0] fifo_level;
  logic [7:0] tx_data1, rx_data1;
  logic       tx_load1, sclk1, mosi1, ss_n1, rx_valid1, busy1, overflow1;
  logic [2:0] fifo_level1;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  pio_spi_tx_bridge #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_load(tx_load), .ovf_clr(ovf_clr),
    .miso(miso), .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .fifo_level(fifo_level), .overflow(overflow)
  );

  pio_spi_tx_bridge #(.CLK_DIV(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data1), .tx_load(tx_load1), .ovf_clr(1'b0),
    .miso(mosi1), .sclk(sclk1), .mosi(mosi1), .ss_n(ss_n1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .busy(busy1), .fifo_level(fifo_level1), .overflow(overflow1)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  // Observed frames of the main instance, reconstructed from the SPI pins.
  typedef struct {
    int         start;
    int         stop;
    int         rises;
    int         first_rise;
    logic [7:0] mosi_b;
    logic [7:0] miso_b;
  } frame_t;

  frame_t     frames[$];
  frame_t     cur;
  int         rx_cyc[$];
  logic [7:0] rx_val[$];
  int         busy_fall = 0;
  int         max_level = 0;
  bit         in_frame = 0;
  bit         slave_rand = 0;
  logic [7:0] slave_fixed = 8'h00;
  logic [7:0] slave_sh = 8'h00;
  int         starts1[$], stops1[$], rises1[$];
  logic [7:0] rx1[$];

  // Reference model: accepted bytes, their push edges and predicted pop edges.
  logic [7:0] m_byte[$];
  int         m_push[$], m_pop[$];
  int         m_last_pop = -1000;
  bit         m_ovf = 0;

  function automatic int m_level(input int t);
    int n = 0;
    foreach (m_push[i]) begin
      if (m_push[i] <= t) n++;
      if (m_pop[i] <= t) n--;
    end
    return n;
  endfunction

  task automatic model_push(input logic [7:0] b, input int t, input bit clr);
    int lvl = 0;
    int p;
    foreach (m_push[i]) begin
      if (m_push[i] < t) lvl++;
      if (m_pop[i] < t) lvl--;
    end
    if (lvl < DEPTH) begin
      p = (t + 1 > m_last_pop + PER) ? t + 1 : m_last_pop + PER;
      m_last_pop = p;
      m_byte.push_back(b);
      m_push.push_back(t);
      m_pop.push_back(p);
      if (clr) m_ovf = 0;
    end else begin
      m_ovf = 1;
    end
  endtask

  // Pin monitor and SPI slave (slave shifts its byte out MSB first, changing after each rise).
  initial begin
    logic prev_ss = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0, prev_ss1 = 1'b1, prev_sclk1 = 1'b0;
    miso = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_frame = 0;
        miso = 1'b0;
      end else begin
        if (prev_ss && !ss_n) begin
          cur.start = cyc; cur.stop = -1; cur.rises = 0; cur.first_rise = -1; cur.mosi_b = 8'h00;
          cur.miso_b = slave_rand ? 8'($urandom) : slave_fixed;
          slave_sh = cur.miso_b;
          miso = slave_sh[7];
          in_frame = 1;
        end
        if (in_frame && !prev_sclk && sclk) begin
          cur.mosi_b = {cur.mosi_b[6:0], mosi};
          if (cur.rises == 0) cur.first_rise = cyc;
          cur.rises++;
          slave_sh = {slave_sh[6:0], 1'b0};
          miso = slave_sh[7];
        end
        if (in_frame && !prev_ss && ss_n) begin
          cur.stop = cyc;
          frames.push_back(cur);
          in_frame = 0;
          miso = 1'b0;
        end
        if (rx_valid) begin
          rx_cyc.push_back(cyc);
          rx_val.push_back(rx_data);
        end
        if (prev_busy && !busy) busy_fall = cyc;
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (prev_ss1 && !ss_n1) starts1.push_back(cyc);
        if (!prev_sclk1 && sclk1 && !ss_n1) rises1.push_back(cyc);
        if (!prev_ss1 && ss_n1) stops1.push_back(cyc);
        if (rx_valid1) rx1.push_back(rx_data1);
      end
      prev_ss = ss_n; prev_sclk = sclk; prev_busy = busy; prev_ss1 = ss_n1; prev_sclk1 = sclk1;
    end
  end

  // Drive one PIO write for the next edge; call at a falling edge.
  task automatic push(input logic [7:0] b, input bit clr);
    tx_data = b; tx_load = 1'b1; ovf_clr = clr;
    model_push(b, cyc + 1, clr);
    @(negedge clk);
    tx_load = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frames.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && (busy || in_frame); i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tx_load = 1'b0; tx_data = 8'h00; ovf_clr = 1'b0; tx_load1 = 1'b0; tx_data1 = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_tests += 10;
    if (sclk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", mosi); end
    if (ss_n !== 1'b1) begin n_fail++; $display("FAIL rst_ss_n: got %b want 1", ss_n); end
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    if (ss_n1 !== 1'b1) begin n_fail++; $display("FAIL rst_ss_n1: got %b want 1", ss_n1); end
    if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_busy1: got %b want 0", busy1); end
  endtask

  task automatic test_single();
    int f0 = frames.size(), r0 = rx_val.size(), m0 = m_byte.size();
    slave_rand = 0; slave_fixed = 8'h3C;
    push(8'hA5, 0);
    wait_frames(f0 + 1, 300);
    repeat (4) @(negedge clk);
    n_tests++;
    if (frames.size() != f0 + 1 || rx_val.size() != r0 + 1) begin
      n_fail++; $display("FAIL single_count: got %0d frames %0d rx want 1 1", frames.size() - f0,
                         rx_val.size() - r0);
    end else begin
      n_tests += 7;
      if (frames[f0].mosi_b !== 8'hA5) begin
        n_fail++; $display("FAIL single_mosi: got %h want a5", frames[f0].mosi_b); end
      if (frames[f0].rises != 8) begin
        n_fail++; $display("FAIL single_rises: got %0d want 8", frames[f0].rises); end
      // Push edge then pop edge: ss_n falls one edge after the push is taken.
      if (frames[f0].start != m_pop[m0]) begin
        n_fail++; $display("FAIL single_start: got %0d want %0d", frames[f0].start, m_pop[m0]); end
      if (frames[f0].first_rise - frames[f0].start != D) begin
        n_fail++; $display("FAIL single_first_rise: got %0d want %0d",
                           frames[f0].first_rise - frames[f0].start, D); end
      if (frames[f0].stop - frames[f0].start != 17 * D) begin
        n_fail++; $display("FAIL single_ss_low: got %0d want %0d",
                           frames[f0].stop - frames[f0].start, 17 * D); end
      if (rx_val[r0] !== 8'h3C) begin
        n_fail++; $display("FAIL single_rx_data: got %h want 3c", rx_val[r0]); end
      if (rx_cyc[r0] - frames[f0].start != 68) begin
        n_fail++; $display("FAIL single_rx_time: got %0d want 68", rx_cyc[r0] - frames[f0].start); end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int f0 = frames.size(), r0 = rx_val.size(), m0 = m_byte.size();
    slave_rand = 1;
    push(8'h01, 0); push(8'h80, 0); push(8'hFF, 0);
    wait_frames(f0 + 3, 600);
    repeat (8) @(negedge clk);
    n_tests++;
    if (frames.size() != f0 + 3 || rx_val.size() != r0 + 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 3", frames.size() - f0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests += 3;
        if (frames[f0+i].mosi_b !== m_byte[m0+i]) begin
          n_fail++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, frames[f0+i].mosi_b, m_byte[m0+i]); end
        if (frames[f0+i].start != m_pop[m0+i]) begin
          n_fail++; $display("FAIL b2b_start[%0d]: got %0d want %0d", i, frames[f0+i].start, m_pop[m0+i]); end
        if (rx_val[r0+i] !== frames[f0+i].miso_b) begin
          n_fail++; $display("FAIL b2b_rx[%0d]: got %h want %h", i, rx_val[r0+i], frames[f0+i].miso_b); end
        if (i > 0) begin
          n_tests++;
          if (frames[f0+i].start - frames[f0+i-1].stop != D) begin
            n_fail++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i,
                               frames[f0+i].start - frames[f0+i-1].stop, D); end
        end
      end
      n_tests++;
      if (busy_fall - frames[f0+2].stop != D) begin
        n_fail++; $display("FAIL b2b_busy_fall: got %0d want %0d", busy_fall - frames[f0+2].stop, D); end
    end
    wait_idle();
  endtask

  task automatic test_overflow();
    int f0 = frames.size(), m0 = m_byte.size();
    max_level = 0;
    for (int i = 0; i < 6; i++) push(8'($urandom), 0);
    n_tests += 3;
    if (max_level != 4) begin n_fail++; $display("FAIL ovf_peak: got %0d want 4", max_level); end
    if (overflow !== m_ovf) begin n_fail++; $display("FAIL ovf_set: got %b want %b", overflow, m_ovf); end
    if (m_byte.size() - m0 != 5) begin
      n_fail++; $display("FAIL ovf_model_accept: got %0d want 5", m_byte.size() - m0); end
    ovf_clr = 1'b1; m_ovf = 0;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_tests++;
    if (overflow !== m_ovf) begin n_fail++; $display("FAIL ovf_clear: got %b want %b", overflow, m_ovf); end
    push(8'h77, 1);
    n_tests += 2;
    if (overflow !== m_ovf) begin n_fail++; $display("FAIL ovf_set_wins: got %b want %b", overflow, m_ovf); end
    if (fifo_level !== 3'(m_level(cyc))) begin
      n_fail++; $display("FAIL ovf_level: got %0d want %0d", fifo_level, m_level(cyc)); end
    wait_frames(f0 + 5, 5 * PER + 100);
    repeat (PER + 10) @(negedge clk);
    n_tests++;
    if (frames.size() != f0 + m_byte.size() - m0) begin
      n_fail++; $display("FAIL ovf_frames: got %0d want %0d", frames.size() - f0, m_byte.size() - m0);
    end else begin
      for (int i = 0; i < m_byte.size() - m0; i++) begin
        n_tests++;
        if (frames[f0+i].mosi_b !== m_byte[m0+i]) begin
          n_fail++; $display("FAIL ovf_byte[%0d]: got %h want %h", i, frames[f0+i].mosi_b, m_byte[m0+i]); end
      end
    end
    ovf_clr = 1'b1; m_ovf = 0; @(negedge clk); ovf_clr = 1'b0;
    wait_idle();
  endtask

  task automatic test_full_pop();
    int f0 = frames.size(), m0 = m_byte.size();
    int e0;
    for (int i = 0; i < 5; i++) push(8'($urandom), 0);
    e0 = m_pop[m0];
    while (cyc < e0 + PER - 1) @(negedge clk);
    push(8'hEE, 0);
    n_tests += 2;
    if (overflow !== m_ovf) begin n_fail++; $display("FAIL fullpop_ovf: got %b want %b", overflow, m_ovf); end
    if (fifo_level !== 3'(m_level(cyc))) begin
      n_fail++; $display("FAIL fullpop_level: got %0d want %0d", fifo_level, m_level(cyc)); end
    wait_frames(f0 + 5, 5 * PER + 100);
    repeat (PER + 10) @(negedge clk);
    n_tests++;
    if (frames.size() != f0 + m_byte.size() - m0) begin
      n_fail++; $display("FAIL fullpop_frames: got %0d want %0d", frames.size() - f0, m_byte.size() - m0);
    end else begin
      for (int i = 0; i < m_byte.size() - m0; i++) begin
        n_tests++;
        if (frames[f0+i].mosi_b !== m_byte[m0+i]) begin
          n_fail++; $display("FAIL fullpop_byte[%0d]: got %h want %h", i, frames[f0+i].mosi_b, m_byte[m0+i]); end
      end
    end
    ovf_clr = 1'b1; m_ovf = 0; @(negedge clk); ovf_clr = 1'b0;
    wait_idle();
  endtask

  task automatic test_random();
    int f0 = frames.size(), r0 = rx_val.size(), m0 = m_byte.size();
    slave_rand = 1;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 50)) @(negedge clk);
      push(8'($urandom), 0);
      n_tests += 2;
      if (fifo_level !== 3'(m_level(cyc))) begin
        n_fail++; $display("FAIL rand_level[%0d]: got %0d want %0d", i, fifo_level, m_level(cyc)); end
      if (overflow !== m_ovf) begin
        n_fail++; $display("FAIL rand_ovf[%0d]: got %b want %b", i, overflow, m_ovf); end
    end
    wait_frames(f0 + m_byte.size() - m0, 12 * PER + 200);
    repeat (8) @(negedge clk);
    n_tests++;
    if (frames.size() != f0 + m_byte.size() - m0 || rx_val.size() != frames.size() - f0 + r0) begin
      n_fail++; $display("FAIL rand_frames: got %0d want %0d", frames.size() - f0, m_byte.size() - m0);
    end else begin
      for (int i = 0; i < m_byte.size() - m0; i++) begin
        n_tests += 3;
        if (frames[f0+i].mosi_b !== m_byte[m0+i]) begin
          n_fail++; $display("FAIL rand_byte[%0d]: got %h want %h", i, frames[f0+i].mosi_b, m_byte[m0+i]); end
        if (frames[f0+i].start != m_pop[m0+i]) begin
          n_fail++; $display("FAIL rand_start[%0d]: got %0d want %0d", i, frames[f0+i].start, m_pop[m0+i]); end
        if (rx_val[r0+i] !== frames[f0+i].miso_b) begin
          n_fail++; $display("FAIL rand_rx[%0d]: got %h want %h", i, rx_val[r0+i], frames[f0+i].miso_b); end
      end
    end
    ovf_clr = 1'b1; m_ovf = 0; @(negedge clk); ovf_clr = 1'b0;
    wait_idle();
  endtask

  task automatic test_clk_div1();
    int s0 = starts1.size(), q0 = rises1.size(), x0 = rx1.size();
    int p;
    tx_data1 = 8'h5A; tx_load1 = 1'b1; p = cyc + 1;
    @(negedge clk);
    tx_data1 = 8'hC3;
    @(negedge clk);
    tx_load1 = 1'b0;
    for (int i = 0; i < 100 && stops1.size() < s0 + 2; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_tests++;
    if (stops1.size() != s0 + 2 || rises1.size() != q0 + 16 || rx1.size() != x0 + 2) begin
      n_fail++; $display("FAIL div1_count: got %0d frames %0d rises want 2 16", stops1.size() - s0,
                         rises1.size() - q0);
    end else begin
      n_tests += 5;
      if (starts1[s0] != p + 1) begin
        n_fail++; $display("FAIL div1_start: got %0d want %0d", starts1[s0], p + 1); end
      if (stops1[s0] - starts1[s0] != 17) begin
        n_fail++; $display("FAIL div1_ss_low: got %0d want 17", stops1[s0] - starts1[s0]); end
      if (starts1[s0+1] - starts1[s0] != 18) begin
        n_fail++; $display("FAIL div1_period: got %0d want 18", starts1[s0+1] - starts1[s0]); end
      if (rx1[x0] !== 8'h5A) begin n_fail++; $display("FAIL div1_rx0: got %h want 5a", rx1[x0]); end
      if (rx1[x0+1] !== 8'hC3) begin n_fail++; $display("FAIL div1_rx1: got %h want c3", rx1[x0+1]); end
      for (int k = 0; k < 8; k++) begin
        n_tests++;
        if (rises1[q0+k] != starts1[s0] + 1 + 2 * k) begin
          n_fail++; $display("FAIL div1_rise[%0d]: got %0d want %0d", k, rises1[q0+k],
                             starts1[s0] + 1 + 2 * k); end
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int f0 = frames.size(), r0 = rx_val.size(), m0 = m_byte.size();
    int e0;
    slave_rand = 1;
    push(8'h3E, 0); push(8'h91, 0); push(8'h4D, 0);
    e0 = m_pop[m0];
    for (int i = 0; i < 200 && cyc < e0 + 30; i++) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_tests += 5;
    if (ss_n !== 1'b1) begin n_fail++; $display("FAIL rmid_ss_n: got %b want 1", ss_n); end
    if (sclk !== 1'b0) begin n_fail++; $display("FAIL rmid_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b0) begin n_fail++; $display("FAIL rmid_mosi: got %b want 0", mosi); end
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rmid_level: got %0d want 0", fifo_level); end
    if (cyc != e0 + 30) begin n_fail++; $display("FAIL rmid_when: got %0d want %0d", cyc, e0 + 30); end
    while (m_byte.size() > m0) begin
      void'(m_byte.pop_back()); void'(m_push.pop_back()); void'(m_pop.pop_back());
    end
    m_last_pop = -1000; m_ovf = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    n_tests += 3;
    if (frames.size() != f0) begin n_fail++; $display("FAIL rmid_frames: got %0d want 0", frames.size() - f0); end
    if (rx_val.size() != r0) begin n_fail++; $display("FAIL rmid_rx_valid: got %0d want 0", rx_val.size() - r0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_random();
    test_clk_div1();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
